// File: rtl/freq_ratio_upd_ctrl.sv
// freq_ratio_upd_ctrl
// Initiator side of the divider's 4-phase ratio-update handshake. Accepts new
// divide ratios from the CSR side, drops values below MIN_RATIO, and presents
// a frozen ratio with ratio_upd_req until the divider has acknowledged. One
// latest-wins pending slot absorbs updates that arrive mid-handshake. Each
// handshake phase is guarded by a timeout. Error flags are sticky.

module freq_ratio_upd_ctrl #(
   parameter int RATIO_W     = 10,
   parameter int RESET_RATIO = 2,
   parameter int MIN_RATIO   = 1,
   parameter int TIMEOUT     = 255,
   parameter int SYNC_STAGES = 2
) (
   input  logic               clkin,
   input  logic               rst,
   input  logic [RATIO_W-1:0] cfg_ratio,
   input  logic               cfg_valid,
   output logic [RATIO_W-1:0] ratio,
   output logic               ratio_upd_req,
   input  logic               ratio_upd_ack,
   output logic               upd_done,
   output logic               busy,
   output logic               err_illegal,
   output logic               err_timeout,
   input  logic               err_clr
);

   localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [RATIO_W-1:0] RESET_VAL = RATIO_W'(RESET_RATIO);
   localparam logic [RATIO_W-1:0] MIN_VAL   = RATIO_W'(MIN_RATIO);
   localparam logic [CNT_W-1:0]   TO_VAL    = CNT_W'(TIMEOUT);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_ACK_LOW = 2'd2
   } state_t;

   state_t             r_state;
   logic [RATIO_W-1:0] r_ratio;
   logic               r_req;
   logic               r_done;
   logic               r_pend_vld;
   logic [RATIO_W-1:0] r_pend_ratio;
   logic               r_abort;      // current ACK_LOW phase ends without upd_done
   logic [CNT_W-1:0]   r_cnt;
   logic               r_err_ill;
   logic               r_err_to;

   logic w_ack_s;
   logic w_illegal;
   logic w_legal;
   logic w_cnt_max;
   logic w_to_fire;

   // Acknowledge synchroniser; every decision below uses the delayed copy.
   generate
      if (SYNC_STAGES == 0) begin : g_nosync
         assign w_ack_s = ratio_upd_ack;
      end else begin : g_sync
         logic [SYNC_STAGES-1:0] r_ack_sync;

         // Shift the raw acknowledge through SYNC_STAGES flops.
         always_ff @(posedge clkin or posedge rst) begin
            if (rst) begin
               r_ack_sync <= {SYNC_STAGES{1'b0}};
            end else begin
               r_ack_sync[0] <= ratio_upd_ack;
               for (int i = 1; i < SYNC_STAGES; i++) begin
                  r_ack_sync[i] <= r_ack_sync[i-1];
               end
            end
         end

         assign w_ack_s = r_ack_sync[SYNC_STAGES-1];
      end
   endgenerate

   assign w_illegal = cfg_valid & (cfg_ratio < MIN_VAL);
   assign w_legal   = cfg_valid & ~w_illegal;
   assign w_cnt_max = (r_cnt == TO_VAL);

   // Timeout fires only when the phase's exit condition is not met this cycle.
   always_comb begin
      w_to_fire = 1'b0;
      case (r_state)
         ST_REQ:     w_to_fire = ~w_ack_s & w_cnt_max;
         ST_ACK_LOW: w_to_fire =  w_ack_s & w_cnt_max;
         default:    w_to_fire = 1'b0;
      endcase
   end

   // Handshake FSM: owns ratio, req, done pulse, pending slot and phase counter.
   always_ff @(posedge clkin or posedge rst) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_ratio      <= RESET_VAL;
         r_req        <= 1'b0;
         r_done       <= 1'b0;
         r_pend_vld   <= 1'b0;
         r_pend_ratio <= {RATIO_W{1'b0}};
         r_abort      <= 1'b0;
         r_cnt        <= {CNT_W{1'b0}};
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               // A request is never raised while the synchronised ack is still high.
               if (w_legal && !w_ack_s) begin
                  r_ratio    <= cfg_ratio;
                  r_req      <= 1'b1;
                  r_cnt      <= {CNT_W{1'b0}};
                  r_abort    <= 1'b0;
                  r_pend_vld <= 1'b0;
                  r_state    <= ST_REQ;
               end else if (w_legal) begin
                  r_pend_ratio <= cfg_ratio;
                  r_pend_vld   <= 1'b1;
               end else if (r_pend_vld && !w_ack_s) begin
                  r_ratio    <= r_pend_ratio;
                  r_req      <= 1'b1;
                  r_cnt      <= {CNT_W{1'b0}};
                  r_abort    <= 1'b0;
                  r_pend_vld <= 1'b0;
                  r_state    <= ST_REQ;
               end else begin
                  r_req <= 1'b0;
               end
            end
            ST_REQ: begin
               if (w_legal) begin
                  r_pend_ratio <= cfg_ratio;
                  r_pend_vld   <= 1'b1;
               end
               if (w_ack_s) begin
                  r_req   <= 1'b0;
                  r_cnt   <= {CNT_W{1'b0}};
                  r_abort <= 1'b0;
                  r_state <= ST_ACK_LOW;
               end else if (w_cnt_max) begin
                  r_req   <= 1'b0;
                  r_cnt   <= {CNT_W{1'b0}};
                  r_abort <= 1'b1;
                  r_state <= ST_ACK_LOW;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            ST_ACK_LOW: begin
               if (!w_ack_s) begin
                  r_done <= ~r_abort;
                  r_cnt  <= {CNT_W{1'b0}};
                  // Chain straight into the next handshake, newest value first.
                  if (w_legal) begin
                     r_ratio    <= cfg_ratio;
                     r_req      <= 1'b1;
                     r_abort    <= 1'b0;
                     r_pend_vld <= 1'b0;
                     r_state    <= ST_REQ;
                  end else if (r_pend_vld) begin
                     r_ratio    <= r_pend_ratio;
                     r_req      <= 1'b1;
                     r_abort    <= 1'b0;
                     r_pend_vld <= 1'b0;
                     r_state    <= ST_REQ;
                  end else begin
                     r_state <= ST_IDLE;
                  end
               end else begin
                  if (w_legal) begin
                     r_pend_ratio <= cfg_ratio;
                     r_pend_vld   <= 1'b1;
                  end
                  // Ack stuck high: counter saturates and the phase no longer counts as success.
                  if (w_cnt_max) begin
                     r_abort <= 1'b1;
                  end else begin
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_req   <= 1'b0;
               r_cnt   <= {CNT_W{1'b0}};
            end
         endcase
      end
   end

   // Sticky error flags; a new error event beats err_clr in the same cycle.
   always_ff @(posedge clkin or posedge rst) begin
      if (rst) begin
         r_err_ill <= 1'b0;
         r_err_to  <= 1'b0;
      end else begin
         if (w_illegal) begin
            r_err_ill <= 1'b1;
         end else if (err_clr) begin
            r_err_ill <= 1'b0;
         end else begin
            r_err_ill <= r_err_ill;
         end
         if (w_to_fire) begin
            r_err_to <= 1'b1;
         end else if (err_clr) begin
            r_err_to <= 1'b0;
         end else begin
            r_err_to <= r_err_to;
         end
      end
   end

   assign ratio         = r_ratio;
   assign ratio_upd_req = r_req;
   assign upd_done      = r_done;
   assign err_illegal   = r_err_ill;
   assign err_timeout   = r_err_to;
   assign busy          = (r_state != ST_IDLE) || r_pend_vld;

endmodule

// File: tb/tb_freq_ratio_upd_ctrl.sv
// Directed, table-driven bench for freq_ratio_upd_ctrl
// (MIN_RATIO=2, TIMEOUT=8, SYNC_STAGES=2, RESET_RATIO=2).
module tb_freq_ratio_upd_ctrl;

   logic       clkin = 1'b0;
   logic       rst;
   logic [9:0] cfg_ratio;
   logic       cfg_valid;
   logic [9:0] ratio;
   logic       ratio_upd_req;
   logic       ratio_upd_ack;
   logic       upd_done;
   logic       busy;
   logic       err_illegal;
   logic       err_timeout;
   logic       err_clr;

   freq_ratio_upd_ctrl #(
      .RATIO_W(10), .RESET_RATIO(2), .MIN_RATIO(2), .TIMEOUT(8), .SYNC_STAGES(2)
   ) dut (
      .clkin(clkin), .rst(rst), .cfg_ratio(cfg_ratio), .cfg_valid(cfg_valid),
      .ratio(ratio), .ratio_upd_req(ratio_upd_req), .ratio_upd_ack(ratio_upd_ack),
      .upd_done(upd_done), .busy(busy), .err_illegal(err_illegal),
      .err_timeout(err_timeout), .err_clr(err_clr)
   );

   always #5 clkin = ~clkin;

   typedef struct {
      logic v;
      int   r;
      logic a;
      logic c;
      int   e_ratio;
      logic e_req;
      logic e_done;
      logic e_busy;
      logic e_ill;
      logic e_to;
   } vec_t;

   vec_t vecs[$];
   int   n_pass  = 0;
   int   n_total = 0;
   int   rises   = 0;
   int   r0      = 0;
   logic prev_req = 1'b0;

   task automatic add(input logic v, input int r, input logic a, input logic c,
                      input int er, input logic eq, input logic ed, input logic eb,
                      input logic ei, input logic et);
      vec_t t;
      t.v = v; t.r = r; t.a = a; t.c = c;
      t.e_ratio = er; t.e_req = eq; t.e_done = ed; t.e_busy = eb; t.e_ill = ei; t.e_to = et;
      vecs.push_back(t);
   endtask

   task automatic chk(input string name, input int idx, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, act, exp);
   endtask

   task automatic chk_out(input string tag, input int idx, input int er, input logic eq,
                          input logic ed, input logic eb, input logic ei, input logic et);
      chk({tag, ".ratio"}, idx, int'(ratio), er);
      chk({tag, ".req"}, idx, int'(ratio_upd_req), int'(eq));
      chk({tag, ".done"}, idx, int'(upd_done), int'(ed));
      chk({tag, ".busy"}, idx, int'(busy), int'(eb));
      chk({tag, ".err_ill"}, idx, int'(err_illegal), int'(ei));
      chk({tag, ".err_to"}, idx, int'(err_timeout), int'(et));
   endtask

   // Drive one cycle of inputs, clock it in, sample on the following falling edge.
   task automatic step(input logic v, input int r, input logic a, input logic c);
      cfg_valid = v; cfg_ratio = r[9:0]; ratio_upd_ack = a; err_clr = c;
      @(posedge clkin);
      @(negedge clkin);
      if (ratio_upd_req && !prev_req) rises++;
      prev_req = ratio_upd_req;
   endtask

   initial begin
      rst = 1'b1; cfg_valid = 1'b0; cfg_ratio = 10'd0; ratio_upd_ack = 1'b0; err_clr = 1'b0;
      repeat (2) @(negedge clkin);
      chk_out("reset", 0, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      @(negedge clkin);

      // Basic update to 7
      add(1,  7, 0, 0,  7, 1, 0, 1, 0, 0);
      add(0,  0, 0, 0,  7, 1, 0, 1, 0, 0);
      add(0,  0, 0, 0,  7, 1, 0, 1, 0, 0);
      add(0,  0, 1, 0,  7, 1, 0, 1, 0, 0);
      add(0,  0, 1, 0,  7, 1, 0, 1, 0, 0);
      add(0,  0, 1, 0,  7, 0, 0, 1, 0, 0);
      add(0,  0, 0, 0,  7, 0, 0, 1, 0, 0);
      add(0,  0, 0, 0,  7, 0, 0, 1, 0, 0);
      add(0,  0, 0, 0,  7, 0, 1, 0, 0, 0);
      add(0,  0, 0, 0,  7, 0, 0, 0, 0, 0);
      // Coalescing: 5, then 9 and 12 during REQ; 9 must never reach ratio
      add(1,  5, 0, 0,  5, 1, 0, 1, 0, 0);
      add(1,  9, 0, 0,  5, 1, 0, 1, 0, 0);
      add(1, 12, 0, 0,  5, 1, 0, 1, 0, 0);
      add(0,  0, 1, 0,  5, 1, 0, 1, 0, 0);
      add(0,  0, 1, 0,  5, 1, 0, 1, 0, 0);
      add(0,  0, 1, 0,  5, 0, 0, 1, 0, 0);
      add(0,  0, 0, 0,  5, 0, 0, 1, 0, 0);
      add(0,  0, 0, 0,  5, 0, 0, 1, 0, 0);
      add(0,  0, 0, 0, 12, 1, 1, 1, 0, 0);
      add(0,  0, 0, 0, 12, 1, 0, 1, 0, 0);
      add(0,  0, 1, 0, 12, 1, 0, 1, 0, 0);
      add(0,  0, 1, 0, 12, 1, 0, 1, 0, 0);
      add(0,  0, 1, 0, 12, 0, 0, 1, 0, 0);
      add(0,  0, 0, 0, 12, 0, 0, 1, 0, 0);
      add(0,  0, 0, 0, 12, 0, 0, 1, 0, 0);
      add(0,  0, 0, 0, 12, 0, 1, 0, 0, 0);
      // Illegal values, clear, set-beats-clear, then MIN_RATIO accepted
      add(1,  1, 0, 0, 12, 0, 0, 0, 1, 0);
      add(0,  0, 0, 1, 12, 0, 0, 0, 0, 0);
      add(1,  0, 0, 1, 12, 0, 0, 0, 1, 0);
      add(0,  0, 0, 1, 12, 0, 0, 0, 0, 0);
      add(1,  2, 0, 0,  2, 1, 0, 1, 0, 0);
      add(0,  0, 1, 0,  2, 1, 0, 1, 0, 0);
      add(0,  0, 1, 0,  2, 1, 0, 1, 0, 0);
      add(0,  0, 1, 0,  2, 0, 0, 1, 0, 0);
      add(0,  0, 0, 0,  2, 0, 0, 1, 0, 0);
      add(0,  0, 0, 0,  2, 0, 0, 1, 0, 0);
      add(0,  0, 0, 0,  2, 0, 1, 0, 0, 0);
      // Request timeout: ack never comes, req drops 9 cycles after rising
      add(1, 20, 0, 0, 20, 1, 0, 1, 0, 0);
      for (int k = 0; k < 8; k++) add(0, 0, 0, 0, 20, 1, 0, 1, 0, 0);
      add(0,  0, 0, 0, 20, 0, 0, 1, 0, 1);
      add(0,  0, 0, 0, 20, 0, 0, 0, 0, 1);
      add(0,  0, 0, 1, 20, 0, 0, 0, 0, 0);
      // Ack stuck high in ACK_LOW
      add(1, 25, 0, 0, 25, 1, 0, 1, 0, 0);
      add(0,  0, 1, 0, 25, 1, 0, 1, 0, 0);
      add(0,  0, 1, 0, 25, 1, 0, 1, 0, 0);
      add(0,  0, 1, 0, 25, 0, 0, 1, 0, 0);
      for (int k = 0; k < 8; k++) add(0, 0, 1, 0, 25, 0, 0, 1, 0, 0);
      add(0,  0, 1, 0, 25, 0, 0, 1, 0, 1);
      add(0,  0, 1, 0, 25, 0, 0, 1, 0, 1);
      add(0,  0, 0, 0, 25, 0, 0, 1, 0, 1);
      add(0,  0, 0, 0, 25, 0, 0, 1, 0, 1);
      add(0,  0, 0, 0, 25, 0, 0, 0, 0, 1);
      add(0,  0, 0, 1, 25, 0, 0, 0, 0, 0);
      // Back-to-back: new value lands as ACK_LOW sees ack low
      add(1, 40, 0, 0, 40, 1, 0, 1, 0, 0);
      add(0,  0, 1, 0, 40, 1, 0, 1, 0, 0);
      add(0,  0, 1, 0, 40, 1, 0, 1, 0, 0);
      add(0,  0, 1, 0, 40, 0, 0, 1, 0, 0);
      add(0,  0, 0, 0, 40, 0, 0, 1, 0, 0);
      add(0,  0, 0, 0, 40, 0, 0, 1, 0, 0);
      add(1, 41, 0, 0, 41, 1, 1, 1, 0, 0);
      add(0,  0, 0, 0, 41, 1, 0, 1, 0, 0);
      add(0,  0, 1, 0, 41, 1, 0, 1, 0, 0);
      add(0,  0, 1, 0, 41, 1, 0, 1, 0, 0);
      add(0,  0, 1, 0, 41, 0, 0, 1, 0, 0);
      add(0,  0, 0, 0, 41, 0, 0, 1, 0, 0);
      add(0,  0, 0, 0, 41, 0, 0, 1, 0, 0);
      add(0,  0, 0, 0, 41, 0, 1, 0, 0, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].v, vecs[i].r, vecs[i].a, vecs[i].c);
         chk_out("vec", i, vecs[i].e_ratio, vecs[i].e_req, vecs[i].e_done,
                 vecs[i].e_busy, vecs[i].e_ill, vecs[i].e_to);
         if (i == 9) r0 = rises;
         if (i == 25) chk("handshakes", i, rises - r0, 2);
      end

      // Asynchronous reset in REQ with a pending value queued
      step(1, 30, 0, 0); chk_out("rst_seq", 0, 30, 1, 0, 1, 0, 0);
      step(1, 50, 0, 0); chk_out("rst_seq", 1, 30, 1, 0, 1, 0, 0);
      cfg_valid = 1'b0;
      #2 rst = 1'b1;
      #1 chk_out("rst_async", 2, 2, 0, 0, 0, 0, 0);
      @(posedge clkin);
      @(negedge clkin);
      rst = 1'b0;
      prev_req = 1'b0;
      step(0, 0, 0, 0); chk_out("post_rst", 3, 2, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0); chk_out("post_rst", 4, 2, 0, 0, 0, 0, 0);
      step(1, 4, 0, 0); chk_out("post_rst", 5, 4, 1, 0, 1, 0, 0);
      step(0, 0, 1, 0); chk_out("post_rst", 6, 4, 1, 0, 1, 0, 0);
      step(0, 0, 1, 0); chk_out("post_rst", 7, 4, 1, 0, 1, 0, 0);
      step(0, 0, 1, 0); chk_out("post_rst", 8, 4, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0); chk_out("post_rst", 9, 4, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0); chk_out("post_rst", 10, 4, 0, 0, 1, 0, 0);
      step(0, 0, 0, 0); chk_out("post_rst", 11, 4, 0, 1, 0, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
